slot_event_detector: RTL and testbench

//  Converts raw per-slot occupancy sensors into debounced one-cycle car_entry/car_exit pulses.

---
 rtl/parking_pkg.sv | 12 +
 rtl/slot_debounce_fsm.sv | 72 +++++++
 rtl/slot_event_detector.sv | 52 +++++
 tb/tb_slot_event_detector.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared slot-state encodings and sizing constants for the parking-lot sensor front end.
package parking_pkg;
  typedef logic [1:0] slot_state_t;

  localparam slot_state_t EMPTY    = 2'd0;
  localparam slot_state_t ARRIVING = 2'd1;
  localparam slot_state_t OCCUPIED = 2'd2;
  localparam slot_state_t LEAVING  = 2'd3;

  localparam int DEFAULT_NUM_SLOTS = 4;
  localparam int DB_CNT_W          = 4;
endpackage

// File: rtl/slot_debounce_fsm.sv
// One slot's debounce FSM: takes an already-synchronised sensor bit and emits
// registered one-cycle entry/exit pulses plus the accepted occupancy flag.
module slot_debounce_fsm
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk_1Hz,
  input  logic reset_n,
  input  logic sync,
  output logic car_entry,
  output logic car_exit,
  output logic occupied
);
  localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  slot_state_t         state, state_nxt;
  logic [DB_CNT_W-1:0] cnt, cnt_nxt;
  logic                entry_nxt, exit_nxt;

  always_ff @(posedge clk_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      car_entry <= 1'b0;
      car_exit  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      car_entry <= entry_nxt;
      car_exit  <= exit_nxt;
    end
  end

  // cnt only moves in the two transitional states, so a steady sensor never wraps it
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    entry_nxt = 1'b0;
    exit_nxt  = 1'b0;
    case (state)
      EMPTY:
        if (sync) begin
          state_nxt = ARRIVING;
          cnt_nxt   = CNT_ONE;
        end
      ARRIVING:
        if (!sync)                state_nxt = EMPTY;
        else if (cnt == CNT_LAST) begin
          state_nxt = OCCUPIED;
          entry_nxt = 1'b1;
        end else                  cnt_nxt = cnt + CNT_ONE;
      OCCUPIED:
        if (!sync) begin
          state_nxt = LEAVING;
          cnt_nxt   = CNT_ONE;
        end
      LEAVING:
        if (sync)                 state_nxt = OCCUPIED;
        else if (cnt == CNT_LAST) begin
          state_nxt = EMPTY;
          exit_nxt  = 1'b1;
        end else                  cnt_nxt = cnt + CNT_ONE;
      default:                    state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    occupied = (state == OCCUPIED) || (state == LEAVING);
  end
endmodule

// File: rtl/slot_event_detector.sv
// Debounced per-slot entry/exit pulse generator with lot occupancy summary.
// Synchronises the raw sensors, runs one debounce FSM per slot, and counts free slots.
module slot_event_detector
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS       = DEFAULT_NUM_SLOTS,
  parameter int DEBOUNCE_CYCLES = 3,
  localparam int CW             = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk_1Hz,
  input  logic                 reset_n,
  input  logic [NUM_SLOTS-1:0] sensor_raw,
  output logic [NUM_SLOTS-1:0] car_entry,
  output logic [NUM_SLOTS-1:0] car_exit,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [CW-1:0]        free_count,
  output logic                 lot_full
);
  logic [NUM_SLOTS-1:0] sync_meta, sensor_sync;
  logic [CW-1:0]        occ_cnt;

  always_ff @(posedge clk_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta   <= '0;
      sensor_sync <= '0;
    end else begin
      sync_meta   <= sensor_raw;
      sensor_sync <= sync_meta;
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    slot_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fsm (
      .clk_1Hz  (clk_1Hz),
      .reset_n  (reset_n),
      .sync     (sensor_sync[s]),
      .car_entry(car_entry[s]),
      .car_exit (car_exit[s]),
      .occupied (occupied[s])
    );
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) occ_cnt = occ_cnt + CW'(occupied[i]);
  end

  assign free_count = CW'(NUM_SLOTS) - occ_cnt;
  assign lot_full   = (free_count == '0);
endmodule

// File: tb/tb_slot_event_detector.sv
// Directed bench for slot_event_detector (4 slots, 3-sample debounce).
module tb_slot_event_detector;
  logic       clk_1Hz = 1'b0;
  logic       reset_n;
  logic [3:0] sensor_raw;
  logic [3:0] car_entry, car_exit, occupied;
  logic [2:0] free_count;
  logic       lot_full;
  int pass_cnt = 0;
  int total    = 0;

  slot_event_detector #(.NUM_SLOTS(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk_1Hz   (clk_1Hz),
    .reset_n   (reset_n),
    .sensor_raw(sensor_raw),
    .car_entry (car_entry),
    .car_exit  (car_exit),
    .occupied  (occupied),
    .free_count(free_count),
    .lot_full  (lot_full)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk_1Hz);
    @(negedge clk_1Hz);
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    sensor_raw = 4'b1111;
    tick(); tick();
    total += 5;
    if (car_entry !== 4'b0000) $display("FAIL rst_entry: got %b want 0000", car_entry); else pass_cnt++;
    if (car_exit  !== 4'b0000) $display("FAIL rst_exit: got %b want 0000", car_exit); else pass_cnt++;
    if (occupied  !== 4'b0000) $display("FAIL rst_occ: got %b want 0000", occupied); else pass_cnt++;
    if (free_count !== 3'd4)   $display("FAIL rst_free: got %0d want 4", free_count); else pass_cnt++;
    if (lot_full  !== 1'b0)    $display("FAIL rst_full: got %b want 0", lot_full); else pass_cnt++;
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (car_entry !== ((k == 5) ? 4'b1111 : 4'b0000))
        $display("FAIL rel_entry_e%0d: got %b want %b", k, car_entry, (k == 5) ? 4'b1111 : 4'b0000);
      else pass_cnt++;
    end
    // clear the lot for the next scenario
    sensor_raw = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (occupied !== 4'b0000) $display("FAIL rst_clear_occ: got %b want 0000", occupied); else pass_cnt++;
  endtask

  task automatic test_entry();
    sensor_raw = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total += 2;
      if (car_entry !== ((k == 5) ? 4'b0001 : 4'b0000))
        $display("FAIL entry_e%0d: got %b want %b", k, car_entry, (k == 5) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
      if (occupied !== ((k >= 5) ? 4'b0001 : 4'b0000))
        $display("FAIL entry_occ_e%0d: got %b want %b", k, occupied, (k >= 5) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
    end
    total++;
    if (free_count !== 3'd3) $display("FAIL entry_free: got %0d want 3", free_count); else pass_cnt++;
  endtask

  task automatic test_glitch();
    sensor_raw = 4'b0101;
    tick(); tick();
    sensor_raw = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      total += 3;
      if (car_entry !== 4'b0000) $display("FAIL glitch_entry_%0d: got %b want 0000", k, car_entry); else pass_cnt++;
      if (car_exit  !== 4'b0000) $display("FAIL glitch_exit_%0d: got %b want 0000", k, car_exit); else pass_cnt++;
      if (occupied  !== 4'b0001) $display("FAIL glitch_occ_%0d: got %b want 0001", k, occupied); else pass_cnt++;
    end
    total++;
    if (free_count !== 3'd3) $display("FAIL glitch_free: got %0d want 3", free_count); else pass_cnt++;
  endtask

  task automatic test_exit_bounce();
    for (int k = 1; k <= 9; k++) begin
      if (k == 1)      sensor_raw = 4'b0000;
      else if (k <= 3) sensor_raw = 4'b0001;
      else             sensor_raw = 4'b0000;
      tick();
      total += 2;
      if (car_exit !== ((k == 8) ? 4'b0001 : 4'b0000))
        $display("FAIL bounce_exit_e%0d: got %b want %b", k, car_exit, (k == 8) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
      if (occupied !== ((k < 8) ? 4'b0001 : 4'b0000))
        $display("FAIL bounce_occ_e%0d: got %b want %b", k, occupied, (k < 8) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
    end
    total++;
    if (free_count !== 3'd4) $display("FAIL bounce_free: got %0d want 4", free_count); else pass_cnt++;
  endtask

  task automatic test_all_full();
    sensor_raw = 4'b1111;
    for (int k = 1; k <= 5; k++) tick();
    total += 3;
    if (car_entry !== 4'b1111) $display("FAIL full_entry: got %b want 1111", car_entry); else pass_cnt++;
    if (lot_full !== 1'b1)     $display("FAIL full_flag: got %b want 1", lot_full); else pass_cnt++;
    if (free_count !== 3'd0)   $display("FAIL full_free: got %0d want 0", free_count); else pass_cnt++;
    sensor_raw = 4'b1101;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (car_exit !== ((k == 5) ? 4'b0010 : 4'b0000))
        $display("FAIL leave1_exit_e%0d: got %b want %b", k, car_exit, (k == 5) ? 4'b0010 : 4'b0000);
      else pass_cnt++;
    end
    total += 3;
    if (lot_full !== 1'b0)     $display("FAIL leave1_full: got %b want 0", lot_full); else pass_cnt++;
    if (free_count !== 3'd1)   $display("FAIL leave1_free: got %0d want 1", free_count); else pass_cnt++;
    if (occupied !== 4'b1101)  $display("FAIL leave1_occ: got %b want 1101", occupied); else pass_cnt++;
  endtask

  task automatic test_reset_mid_arriving();
    sensor_raw = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
    sensor_raw = 4'b1000;
    // four edges leave slot3 in ARRIVING with cnt=2
    for (int k = 0; k < 4; k++) tick();
    reset_n = 1'b0;
    tick();
    total += 2;
    if (car_entry !== 4'b0000) $display("FAIL midrst_entry: got %b want 0000", car_entry); else pass_cnt++;
    if (occupied  !== 4'b0000) $display("FAIL midrst_occ: got %b want 0000", occupied); else pass_cnt++;
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (car_entry !== ((k == 5) ? 4'b1000 : 4'b0000))
        $display("FAIL midrst_entry_e%0d: got %b want %b", k, car_entry, (k == 5) ? 4'b1000 : 4'b0000);
      else pass_cnt++;
    end
    total++;
    if (free_count !== 3'd3) $display("FAIL midrst_free: got %0d want 3", free_count); else pass_cnt++;
  endtask

  initial begin
    reset_n    = 1'b0;
    sensor_raw = 4'b0000;
    @(negedge clk_1Hz);
    test_reset();
    test_entry();
    test_glitch();
    test_exit_bounce();
    test_all_full();
    test_reset_mid_arriving();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
